// File: rtl/or1200_dual_fwdsel_pkg.sv
// Shared select encodings, FSM states and tracking-entry type for the
// dual-issue operand-select / hazard controller.
package or1200_dual_fwdsel_pkg;

   localparam int OR1200_SEL_WIDTH = 2;

   localparam logic [OR1200_SEL_WIDTH-1:0] OR1200_SEL_RF      = 2'd0;
   localparam logic [OR1200_SEL_WIDTH-1:0] OR1200_SEL_IMM     = 2'd1;
   localparam logic [OR1200_SEL_WIDTH-1:0] OR1200_SEL_EX_FORW = 2'd2;
   localparam logic [OR1200_SEL_WIDTH-1:0] OR1200_SEL_WB_FORW = 2'd3;

   typedef enum logic {
      OR1200_FWDSEL_RUN   = 1'b0,
      OR1200_FWDSEL_STALL = 1'b1
   } fwdsel_state_e;

   typedef struct packed {
      logic       valid;
      logic       we;
      logic [4:0] addr;
   } trk_t;

   // r0 is hard-wired zero, so it never forwards and never hazards.
   function automatic logic trk_hit(trk_t e, logic [4:0] src);
      return e.valid && e.we && (e.addr == src) && (src != 5'd0);
   endfunction

   function automatic logic [OR1200_SEL_WIDTH-1:0] fwd_sel(logic imm, logic haz,
                                                           logic ex_hit, logic wb_hit);
      if (imm)         return OR1200_SEL_IMM;
      else if (haz)    return OR1200_SEL_RF;
      else if (ex_hit) return OR1200_SEL_EX_FORW;
      else if (wb_hit) return OR1200_SEL_WB_FORW;
      else             return OR1200_SEL_RF;
   endfunction

endpackage

// File: rtl/or1200_fwd_match.sv
// Compares one source operand against the EX/WB tracking entries of both
// lanes; LANE selects which lane the operand belongs to.
module or1200_fwd_match
   import or1200_dual_fwdsel_pkg::*;
#(
   parameter int LANE = 0
) (
   input  logic       [4:0] src,
   input  trk_t       [1:0] ex_trk,
   input  trk_t       [1:0] wb_trk,
   input  logic             own_load,
   output logic             ex_hit,
   output logic             wb_hit,
   output logic             load_hit,
   output logic             xlane_hit
);
   localparam int OTHER = 1 - LANE;

   assign ex_hit    = trk_hit(ex_trk[LANE], src);
   assign wb_hit    = trk_hit(wb_trk[LANE], src);
   assign load_hit  = ex_hit && own_load;
   assign xlane_hit = trk_hit(ex_trk[OTHER], src) || trk_hit(wb_trk[OTHER], src);

endmodule

// File: rtl/or1200_dual_fwdsel.sv
// Dual-issue operand-select and hazard controller: tracks both lanes'
// destinations through EX/WB, drives the operand-mux selects and stall request.
//
//   state  | meaning
//   RUN    | no stall in the previous cycle
//   STALL  | stall_req was high in the previous cycle
module or1200_dual_fwdsel
   import or1200_dual_fwdsel_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        id_freeze,
   input  logic                        ex_freeze,
   input  logic                        wb_freeze,
   input  logic [4:0]                  id_rfaddra,
   input  logic [4:0]                  id_rfaddrb,
   input  logic [4:0]                  id_rfaddra2,
   input  logic [4:0]                  id_rfaddrb2,
   input  logic                        id_rfwe,
   input  logic                        id_rfwe2,
   input  logic [4:0]                  id_rfaddrw,
   input  logic [4:0]                  id_rfaddrw2,
   input  logic                        id_load,
   input  logic                        id_load2,
   input  logic                        id_imm_b,
   input  logic                        id_imm_b2,
   input  logic                        perf_clr,
   output logic [OR1200_SEL_WIDTH-1:0] sel_a,
   output logic [OR1200_SEL_WIDTH-1:0] sel_b,
   output logic [OR1200_SEL_WIDTH-1:0] sel_a2,
   output logic [OR1200_SEL_WIDTH-1:0] sel_b2,
   output logic                        stall_req,
   output logic [CNT_W-1:0]            stall_count,
   output logic                        dbg_stall_first
);
   trk_t [1:0]    id_trk, ex_trk, wb_trk;
   logic [1:0]    ex_load;
   logic [3:0]    ex_hit, wb_hit, load_hit, xlane_hit, haz;
   fwdsel_state_e state, state_nxt;

   assign id_trk[0] = '{valid: 1'b1, we: id_rfwe,  addr: id_rfaddrw};
   assign id_trk[1] = '{valid: 1'b1, we: id_rfwe2, addr: id_rfaddrw2};

   // WB carries no load flag: a load in WB already has its data and forwards normally.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_trk  <= '0;
         wb_trk  <= '0;
         ex_load <= '0;
      end else begin
         if (!ex_freeze) begin
            ex_trk  <= id_freeze ? '0 : id_trk;
            ex_load <= id_freeze ? 2'b00 : {id_load2, id_load};
         end
         if (!wb_freeze)
            wb_trk <= ex_freeze ? '0 : ex_trk;
      end
   end

   or1200_fwd_match #(.LANE(0)) u_match_a (
      .src(id_rfaddra), .ex_trk(ex_trk), .wb_trk(wb_trk), .own_load(ex_load[0]),
      .ex_hit(ex_hit[0]), .wb_hit(wb_hit[0]), .load_hit(load_hit[0]), .xlane_hit(xlane_hit[0])
   );
   or1200_fwd_match #(.LANE(0)) u_match_b (
      .src(id_rfaddrb), .ex_trk(ex_trk), .wb_trk(wb_trk), .own_load(ex_load[0]),
      .ex_hit(ex_hit[1]), .wb_hit(wb_hit[1]), .load_hit(load_hit[1]), .xlane_hit(xlane_hit[1])
   );
   or1200_fwd_match #(.LANE(1)) u_match_a2 (
      .src(id_rfaddra2), .ex_trk(ex_trk), .wb_trk(wb_trk), .own_load(ex_load[1]),
      .ex_hit(ex_hit[2]), .wb_hit(wb_hit[2]), .load_hit(load_hit[2]), .xlane_hit(xlane_hit[2])
   );
   or1200_fwd_match #(.LANE(1)) u_match_b2 (
      .src(id_rfaddrb2), .ex_trk(ex_trk), .wb_trk(wb_trk), .own_load(ex_load[1]),
      .ex_hit(ex_hit[3]), .wb_hit(wb_hit[3]), .load_hit(load_hit[3]), .xlane_hit(xlane_hit[3])
   );

   assign haz[0] = load_hit[0] | xlane_hit[0];
   assign haz[1] = (load_hit[1] | xlane_hit[1]) & ~id_imm_b;
   assign haz[2] = load_hit[2] | xlane_hit[2];
   assign haz[3] = (load_hit[3] | xlane_hit[3]) & ~id_imm_b2;

   assign stall_req = |haz;

   assign sel_a  = fwd_sel(1'b0,      haz[0], ex_hit[0], wb_hit[0]);
   assign sel_b  = fwd_sel(id_imm_b,  haz[1], ex_hit[1], wb_hit[1]);
   assign sel_a2 = fwd_sel(1'b0,      haz[2], ex_hit[2], wb_hit[2]);
   assign sel_b2 = fwd_sel(id_imm_b2, haz[3], ex_hit[3], wb_hit[3]);

   always_ff @(posedge clk) begin
      if (rst) state <= OR1200_FWDSEL_RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         OR1200_FWDSEL_RUN:   if (stall_req)  state_nxt = OR1200_FWDSEL_STALL;
         OR1200_FWDSEL_STALL: if (!stall_req) state_nxt = OR1200_FWDSEL_RUN;
         default:             state_nxt = OR1200_FWDSEL_RUN;
      endcase
   end

   always_comb begin
      dbg_stall_first = (state == OR1200_FWDSEL_RUN) && stall_req;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_count <= '0;
      else if (perf_clr)
         stall_count <= '0;
      else if (stall_req && (stall_count != {CNT_W{1'b1}}))
         stall_count <= stall_count + 1'b1;
   end

endmodule

// File: tb/tb_or1200_dual_fwdsel.sv
// Directed + random bench for or1200_dual_fwdsel against a pipeline-level
// reference model; CNT_W is 4 so counter saturation is reachable quickly.
module tb_or1200_dual_fwdsel;
   localparam int CW = 4;
   localparam logic [1:0] S_RF = 2'd0, S_IMM = 2'd1, S_EX = 2'd2, S_WB = 2'd3;

   logic clk = 1'b0;
   logic rst, id_freeze, ex_freeze, wb_freeze, perf_clr;
   logic [4:0] id_rfaddra, id_rfaddrb, id_rfaddra2, id_rfaddrb2, id_rfaddrw, id_rfaddrw2;
   logic id_rfwe, id_rfwe2, id_load, id_load2, id_imm_b, id_imm_b2;
   logic [1:0] sel_a, sel_b, sel_a2, sel_b2;
   logic stall_req, dbg_stall_first;
   logic [CW-1:0] stall_count;

   int n_asrt = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   or1200_dual_fwdsel #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_freeze(id_freeze), .ex_freeze(ex_freeze), .wb_freeze(wb_freeze),
      .id_rfaddra(id_rfaddra), .id_rfaddrb(id_rfaddrb), .id_rfaddra2(id_rfaddra2), .id_rfaddrb2(id_rfaddrb2),
      .id_rfwe(id_rfwe), .id_rfwe2(id_rfwe2), .id_rfaddrw(id_rfaddrw), .id_rfaddrw2(id_rfaddrw2),
      .id_load(id_load), .id_load2(id_load2), .id_imm_b(id_imm_b), .id_imm_b2(id_imm_b2),
      .perf_clr(perf_clr), .sel_a(sel_a), .sel_b(sel_b), .sel_a2(sel_a2), .sel_b2(sel_b2),
      .stall_req(stall_req), .stall_count(stall_count), .dbg_stall_first(dbg_stall_first)
   );

   // Reference model: one instruction record per lane in EX and in WB.
   typedef struct { bit v; bit we; int addr; bit ld; } ent_t;
   ent_t m_ex[2];
   ent_t m_wb[2];
   int   m_cnt = 0;
   bit   m_stalled = 0;
   bit   auto_frz = 1;
   bit   extra_frz = 0;

   function automatic bit writes(ent_t e, int src);
      return e.v && e.we && e.addr == src;
   endfunction

   function automatic bit m_haz(int lane, int src, bit imm);
      if (imm || src == 0) return 0;
      if (writes(m_ex[1-lane], src) || writes(m_wb[1-lane], src)) return 1;
      if (writes(m_ex[lane], src) && m_ex[lane].ld) return 1;
      return 0;
   endfunction

   function automatic logic [1:0] m_sel(int lane, int src, bit imm);
      if (imm) return S_IMM;
      if (src == 0 || m_haz(lane, src, imm)) return S_RF;
      if (writes(m_ex[lane], src)) return S_EX;
      if (writes(m_wb[lane], src)) return S_WB;
      return S_RF;
   endfunction

   function automatic bit m_stall();
      return m_haz(0, int'(id_rfaddra), 0) || m_haz(0, int'(id_rfaddrb), id_imm_b) ||
             m_haz(1, int'(id_rfaddra2), 0) || m_haz(1, int'(id_rfaddrb2), id_imm_b2);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nop();
      {id_rfaddra, id_rfaddrb, id_rfaddra2, id_rfaddrb2, id_rfaddrw, id_rfaddrw2} = '0;
      {id_rfwe, id_rfwe2, id_load, id_load2, id_imm_b, id_imm_b2} = '0;
   endtask

   task automatic settle();
      if (auto_frz) id_freeze = m_stall() | extra_frz;
      @(negedge clk);
      chk("sel_a",  32'(sel_a),  32'(m_sel(0, int'(id_rfaddra), 0)));
      chk("sel_b",  32'(sel_b),  32'(m_sel(0, int'(id_rfaddrb), id_imm_b)));
      chk("sel_a2", 32'(sel_a2), 32'(m_sel(1, int'(id_rfaddra2), 0)));
      chk("sel_b2", 32'(sel_b2), 32'(m_sel(1, int'(id_rfaddrb2), id_imm_b2)));
      chk("stall_req", 32'(stall_req), 32'(m_stall()));
      chk("stall_count", 32'(stall_count), 32'(m_cnt));
      chk("dbg_stall_first", 32'(dbg_stall_first), 32'(m_stall() && !m_stalled));
   endtask

   task automatic tick();
      bit   st;
      ent_t bub;
      ent_t id_e[2];
      st  = m_stall();
      bub = '{v: 0, we: 0, addr: 0, ld: 0};
      id_e[0] = '{v: 1, we: id_rfwe,  addr: int'(id_rfaddrw),  ld: id_load};
      id_e[1] = '{v: 1, we: id_rfwe2, addr: int'(id_rfaddrw2), ld: id_load2};
      @(posedge clk);
      if (rst) begin
         m_ex[0] = bub; m_ex[1] = bub; m_wb[0] = bub; m_wb[1] = bub;
         m_cnt = 0;
         m_stalled = 0;
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (!wb_freeze) m_wb[l] = ex_freeze ? bub : m_ex[l];
            if (!ex_freeze) m_ex[l] = id_freeze ? bub : id_e[l];
         end
         if (perf_clr)                          m_cnt = 0;
         else if (st && m_cnt < (1 << CW) - 1)  m_cnt = m_cnt + 1;
         m_stalled = st;
      end
      #1;
   endtask

   initial begin
      rst = 1; id_freeze = 0; ex_freeze = 0; wb_freeze = 0; perf_clr = 0;
      nop();
      id_imm_b = 1;
      tick();
      settle();
      chk("rst_imm_b", 32'(sel_b), 32'(S_IMM));
      chk("rst_sel_a", 32'(sel_a), 32'(S_RF));
      chk("rst_stall", 32'(stall_req), 32'd0);
      chk("rst_cnt",   32'(stall_count), 32'd0);
      rst = 0; nop(); tick();

      // lane-1 ALU result forwarded from EX, then from WB
      nop(); id_rfwe = 1; id_rfaddrw = 5'd3; settle(); tick();
      nop(); id_rfaddra = 5'd3; settle(); chk("t1_ex_forw", 32'(sel_a), 32'(S_EX)); tick();
      nop(); id_rfaddra = 5'd3; settle(); chk("t1_wb_forw", 32'(sel_a), 32'(S_WB)); tick();

      // load-use: one stall cycle, then WB forward
      nop(); id_rfwe = 1; id_rfaddrw = 5'd5; id_load = 1; settle(); tick();
      nop(); id_rfaddra = 5'd5; settle(); chk("t2_stall", 32'(stall_req), 32'd1); tick();
      settle();
      chk("t2_release", 32'(stall_req), 32'd0);
      chk("t2_wb_forw", 32'(sel_a), 32'(S_WB));
      chk("t2_count",   32'(stall_count), 32'd1);
      tick();
      nop(); perf_clr = 1; settle(); tick(); perf_clr = 0;

      // cross-lane: lane-2 writer, lane-1 reader -> 2 stall cycles
      nop(); id_rfwe2 = 1; id_rfaddrw2 = 5'd7; settle(); tick();
      nop(); id_rfaddrb = 5'd7; settle(); chk("t3_stall1", 32'(stall_req), 32'd1); tick();
      settle(); chk("t3_stall2", 32'(stall_req), 32'd1); tick();
      settle();
      chk("t3_release", 32'(stall_req), 32'd0);
      chk("t3_sel_b",   32'(sel_b), 32'(S_RF));
      chk("t3_count",   32'(stall_count), 32'd2);
      tick();

      // r0 never forwards; immediate B wins over a matching address
      nop(); id_rfwe = 1; id_rfaddrw = 5'd0; id_rfwe2 = 1; id_rfaddrw2 = 5'd6; settle(); tick();
      nop(); id_rfaddra2 = 5'd6; id_rfaddrb2 = 5'd6; id_imm_b2 = 1; settle();
      chk("t4_r0_a",  32'(sel_a),  32'(S_RF));
      chk("t4_r0_b",  32'(sel_b),  32'(S_RF));
      chk("t4_a2_ex", 32'(sel_a2), 32'(S_EX));
      chk("t4_imm",   32'(sel_b2), 32'(S_IMM));
      chk("t4_nostall", 32'(stall_req), 32'd0);
      tick();

      // saturation under a held freeze, then perf_clr mid-stall, then reset mid-stall
      nop(); id_rfwe = 1; id_rfaddrw = 5'd9; id_load = 1; settle(); tick();
      nop(); id_rfaddra = 5'd9; auto_frz = 0; id_freeze = 1; ex_freeze = 1;
      for (int i = 0; i < 20; i++) begin settle(); tick(); end
      settle();
      chk("t5_saturate", 32'(stall_count), 32'hF);
      chk("t5_held",     32'(stall_req), 32'd1);
      perf_clr = 1; tick(); perf_clr = 0;
      settle(); chk("t5_clr", 32'(stall_count), 32'd0); tick();
      rst = 1; tick();
      settle();
      chk("t6_stall", 32'(stall_req), 32'd0);
      chk("t6_sels",  32'({sel_a, sel_b, sel_a2, sel_b2}), 32'd0);
      chk("t6_count", 32'(stall_count), 32'd0);
      rst = 0; id_freeze = 0; ex_freeze = 0; auto_frz = 1; nop(); tick();

      // random traffic on a small register window to provoke hits
      for (int i = 0; i < 400; i++) begin
         if (!id_freeze) begin
            id_rfaddra  = 5'($urandom_range(0, 7));
            id_rfaddrb  = 5'($urandom_range(0, 7));
            id_rfaddra2 = 5'($urandom_range(0, 7));
            id_rfaddrb2 = 5'($urandom_range(0, 7));
            id_rfaddrw  = 5'($urandom_range(0, 7));
            id_rfaddrw2 = 5'($urandom_range(0, 7));
            id_rfwe   = 1'($urandom_range(0, 1));
            id_rfwe2  = 1'($urandom_range(0, 1));
            id_load   = ($urandom_range(0, 3) == 0);
            id_load2  = ($urandom_range(0, 3) == 0);
            id_imm_b  = ($urandom_range(0, 3) == 0);
            id_imm_b2 = ($urandom_range(0, 3) == 0);
         end
         ex_freeze = ($urandom_range(0, 9) == 0);
         wb_freeze = ($urandom_range(0, 9) == 0);
         perf_clr  = ($urandom_range(0, 19) == 0);
         extra_frz = ($urandom_range(0, 9) == 0);
         settle();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/or1200_dual_fwdsel.md
# or1200_dual_fwdsel

Dual-issue operand-select and hazard controller for the OR1200 CPU. Tracks the destination registers of both issue lanes through EX and WB and drives the four select buses of `or1200_operandmuxes` (`sel_a`, `sel_b`, `sel_a2`, `sel_b2`). Requests a pipeline stall when an operand cannot be forwarded, and keeps a saturating stall-cycle counter. It sits in the control path between the ID-stage decoders and the operand muxes.

## Interface
- `CNT_W`, default 16: width of the stall-cycle counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `id_freeze`, `ex_freeze`, `wb_freeze` in 1 each: stage freezes from the freeze unit.
- `id_rfaddra`, `id_rfaddrb`, `id_rfaddra2`, `id_rfaddrb2` in 5 each: source register addresses of the lane-1 and lane-2 instructions in ID.
- `id_rfwe`, `id_rfwe2` in 1 each: the ID instruction writes a register.
- `id_rfaddrw`, `id_rfaddrw2` in 5 each: destination register addresses in ID.
- `id_load`, `id_load2` in 1 each: the ID instruction is a load.
- `id_imm_b`, `id_imm_b2` in 1 each: operand B is the immediate.
- `perf_clr` in 1: clears `stall_count`.
- `sel_a`, `sel_b`, `sel_a2`, `sel_b2` out `OR1200_SEL_WIDTH` each: operand selects.
- `stall_req` out 1: hazard stall request to the freeze unit.
- `stall_count` out `CNT_W`: saturating count of stall cycles.

## Operation
- **Tracking registers** (valid, we, addr, load) exist per lane for EX and for WB.
  - When `!ex_freeze`, EX loads the ID fields. If `id_freeze` is 1, EX loads a bubble (valid=0) instead.
  - When `!wb_freeze`, WB loads the EX fields. If `ex_freeze` is 1, WB loads a bubble instead.
- **Match rule.** A source matches a stage entry when all hold:
  - the entry is valid, has we=1, and is in the same lane as the source;
  - its address equals the source address;
  - the source address is not 0 (r0 is never forwarded).
- **Select priority, per operand:**
  1. For operand B only: the immediate flag gives `OR1200_SEL_IMM`.
  2. A same-lane EX match gives `OR1200_SEL_EX_FORW`.
  3. A same-lane WB match gives `OR1200_SEL_WB_FORW`.
  4. Otherwise `OR1200_SEL_RF`.
  - Lane 1 forwards only from `ex_forw`/`wb_forw`; lane 2 only from `ex_forw2`/`wb_forw2`.
- **Hazards.** Each of the following asserts `stall_req`:
  - Load-use: a same-lane EX match whose entry has load=1.
  - Cross-lane: a nonzero source equals the valid, written destination of the opposite lane in EX or in WB.
  - During either hazard, the affected select is `OR1200_SEL_RF`.
  - Operands selected as immediates never cause a hazard.
- **Hazards within an issue pair** (lane 2 reading lane 1's ID destination) are resolved by the issue unit upstream and are ignored here.
- **FSM** has two states, RUN and STALL.
  - RUN goes to STALL when `stall_req`=1. STALL goes to RUN when `stall_req`=0.
  - The state is used only to flag the first stall cycle on an internal debug signal.
- **Counter.** `stall_count` increments in every cycle with `stall_req`=1 and saturates at all-ones. `perf_clr` has priority over the increment.

## Timing
- Reset:
  - all tracking valid bits become 0;
  - FSM goes to RUN;
  - `stall_count` becomes 0;
  - the selects become `OR1200_SEL_RF`, or `OR1200_SEL_IMM` where the immediate flag is 1;
  - `stall_req` becomes 0.
- `sel_*` and `stall_req` are combinational from the ID inputs and the tracking registers. The operand muxes register operands on `!ex_freeze`.
- Load-use stall lasts exactly 1 cycle: the load moves to WB and the select becomes `OR1200_SEL_WB_FORW`.
- Cross-lane stall:
  - producer in EX: 2 cycles;
  - producer in WB: 1 cycle, because the register-file write completes that cycle.
- A reset asserted mid-stall clears the stall on the next edge.
- If freezes are held, the tracking registers hold as well, and the hazard persists without corrupting state.

## Structure
- The select encodings (`OR1200_SEL_*`, `OR1200_SEL_WIDTH`) stay in `or1200_defines.v`. Add `OR1200_FWDSEL_RUN` and `OR1200_FWDSEL_STALL` there as well.
- The per-lane match logic is one sub-module, `or1200_fwd_match`. It is instantiated once per operand (four instances) and outputs ex_hit, wb_hit, load_hit and xlane_hit.

## Test plan
- Lane 1 at ID writes r3 (non-load); the next pair reads r3 on `sel_a` → `sel_a`=`OR1200_SEL_EX_FORW`, and one cycle later `OR1200_SEL_WB_FORW` for a reader of r3 two instructions back.
- Lane-1 load to r5 followed by a lane-1 reader of r5 → `stall_req`=1 for 1 cycle, then `sel_a`=`OR1200_SEL_WB_FORW`; `stall_count`=1.
- Lane 2 writes r7 and the next lane-1 instruction reads r7 on B → `stall_req` high for 2 cycles, then `sel_b`=`OR1200_SEL_RF`; `stall_count`=2.
- Source r0 matching a destination of r0 with we=1 → `OR1200_SEL_RF` and no stall. `id_imm_b2`=1 → `sel_b2`=`OR1200_SEL_IMM` even when that operand's address matches.
- With `CNT_W`=4, hold a hazard under `ex_freeze` for 20 cycles → counter saturates at 4'hF. A `perf_clr` pulse during the stall → 0 on the next edge.
- `rst` asserted during a stall → the next cycle shows `stall_req`=0, all selects `OR1200_SEL_RF` and `stall_count`=0.
